// File: rtl/eda_result_reader.sv
// eda_result_reader: scans the result RAM row-major and streams each word with row/col/last tags
// over valid/ready, using a 2-entry buffer and credit-based read issue.
module eda_result_reader #(
    parameter int M          = 6,
    parameter int N          = 6,
    parameter int DATA_WIDTH = 8,
    parameter int I_WIDTH    = $clog2(M),
    parameter int J_WIDTH    = $clog2(N),
    parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [I_WIDTH-1:0]    out_row,
    output logic [J_WIDTH-1:0]    out_col,
    output logic                  out_last
);
    localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M - 1);
    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N - 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [I_WIDTH-1:0]    ri, pend_row;
    logic [J_WIDTH-1:0]    rj, pend_col;
    logic                  pend_valid, pend_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [I_WIDTH-1:0]    fifo_row  [2];
    logic [J_WIDTH-1:0]    fifo_col  [2];
    logic                  fifo_last [2];
    logic                  wp, rp, pop, rd_last;
    logic [1:0]            cnt;
    logic [2:0]            used;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign rd_addr   = {ri, rj};
    assign rd_last   = ri == I_LAST && rj == J_LAST;
    assign out_valid = cnt != 2'd0;
    assign pop       = out_valid && out_ready;
    // buffered words plus the read in flight, less what leaves this cycle, must leave room
    assign used      = 3'(cnt) + 3'(pend_valid) - 3'(pop);
    assign rd_en     = state == RUN && used < 3'd2;
    assign out_data  = out_valid ? fifo_data[rp] : '0;
    assign out_row   = out_valid ? fifo_row[rp] : '0;
    assign out_col   = out_valid ? fifo_col[rp] : '0;
    assign out_last  = out_valid && fifo_last[rp];
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = rd_en && rd_last ? DRAIN : RUN;
            DRAIN:   state_nxt = pop && out_last ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ri         <= '0;
            rj         <= '0;
            pend_valid <= 1'b0;
            pend_row   <= '0;
            pend_col   <= '0;
            pend_last  <= 1'b0;
            cnt        <= 2'd0;
            wp         <= 1'b0;
            rp         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                ri <= '0;
                rj <= '0;
            end else if (rd_en && !rd_last) begin
                rj <= rj == J_LAST ? '0 : rj + J_WIDTH'(1);
                ri <= rj == J_LAST ? ri + I_WIDTH'(1) : ri;
            end
            pend_valid <= rd_en;
            if (rd_en) begin
                pend_row  <= ri;
                pend_col  <= rj;
                pend_last <= rd_last;
            end
            if (pend_valid) begin
                fifo_data[wp] <= rd_data;
                fifo_row[wp]  <= pend_row;
                fifo_col[wp]  <= pend_col;
                fifo_last[wp] <= pend_last;
                wp            <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + 2'(pend_valid) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_eda_result_reader.sv
// tb_eda_result_reader: randomized frames against a queue-based model of the expected word stream,
// plus a 5x3 instance for address padding.
module tb_eda_result_reader;
    localparam int M = 6, N = 6;
    typedef struct {logic [7:0] d; logic [2:0] r; logic [2:0] c; logic l;} word_t;
    logic       clk = 0, reset = 1, start = 0, out_ready = 0;
    logic       busy, done, rd_en, out_valid, out_last;
    logic [5:0] rd_addr;
    logic [7:0] rd_data, out_data;
    logic [2:0] out_row, out_col;
    logic [7:0] ram [64];
    logic       p_start = 0, p_busy, p_done, p_rd_en, p_out_valid, p_out_last;
    logic [4:0] p_rd_addr;
    logic [7:0] p_rd_data, p_out_data;
    logic [2:0] p_out_row;
    logic [1:0] p_out_col;
    logic [7:0] ram_p [32];
    int checks = 0, failures = 0, reads = 0, pops = 0, done_cnt = 0;
    bit exp_busy = 0, exp_done = 0, mon = 0, hs, nd;
    logic [7:0] last_hs_data = 0;
    word_t q[$], p_word_q[$];
    logic [4:0] p_addr_q[$];

    eda_result_reader dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );
    eda_result_reader #(.M(5), .N(3)) dut_p (
        .clk(clk), .reset(reset), .start(p_start), .busy(p_busy), .done(p_done),
        .rd_en(p_rd_en), .rd_addr(p_rd_addr), .rd_data(p_rd_data),
        .out_valid(p_out_valid), .out_ready(1'b1), .out_data(p_out_data),
        .out_row(p_out_row), .out_col(p_out_col), .out_last(p_out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];
    always @(posedge clk) if (p_rd_en) p_rd_data <= ram_p[p_rd_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram(input bit ident);
        for (int a = 0; a < 64; a++) ram[a] = ident ? 8'(a) : 8'($urandom);
    endtask

    task automatic load_frame();
        word_t w;
        q.delete();
        for (int n = 0; n < M * N; n++) begin
            w.r = 3'(n / N);
            w.c = 3'(n % N);
            w.d = ram[6'({w.r, w.c})];
            w.l = n == M * N - 1;
            q.push_back(w);
        end
    endtask

    // model: the frame's full word list is queued at the accepted start; the DUT must present its head
    always @(negedge clk) if (mon) begin
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        if (out_valid) begin
            if (q.size() == 0) chk("spurious_valid", out_valid, 0);
            else begin
                chk("out_data", out_data, q[0].d);
                chk("out_row", out_row, q[0].r);
                chk("out_col", out_col, q[0].c);
                chk("out_last", out_last, q[0].l);
            end
        end
        if (rd_en) begin
            chk("rd_when_idle", !exp_busy, 0);
            chk("rd_in_range", reads < M * N, 1);
            chk("rd_addr", rd_addr, ((reads / N) << 3) | (reads % N));
            reads++;
        end
        hs = out_valid && out_ready && q.size() > 0;
        nd = hs && q[0].l;
        if (hs) begin
            last_hs_data = q[0].d;
            void'(q.pop_front());
            pops++;
        end
        chk("unpopped_le2", (reads - pops) > 2, 0);
        if (done) done_cnt++;
        if (reset) begin
            exp_busy = 0;
            q.delete();
            reads = 0;
            pops = 0;
        end else if (!exp_busy && start) begin
            exp_busy = 1;
            load_frame();
            reads = 0;
            pops = 0;
        end else if (exp_done) exp_busy = 0;
        exp_done = reset ? 0 : nd;
    end

    always @(negedge clk) if (mon) begin
        if (p_rd_en) p_addr_q.push_back(p_rd_addr);
        if (p_out_valid) p_word_q.push_back('{p_out_data, p_out_row, 3'(p_out_col), p_out_last});
    end

    // mode: 0 ready high, 1 random ready, 2 stall after first valid, 3 start at word 10, 4 reset at word 20
    task automatic run_frame(input int mode);
        int k, fv, g;
        bit fired;
        g = 0;
        while (busy && g < 100) begin
            cycle();
            g++;
        end
        start = 1;
        out_ready = mode != 2;
        cycle();
        start = 0;
        if (mode == 0) begin
            chk("model_w6", q[6].d, 8'h08);
            chk("model_w35", q[35].d, 8'h2D);
            chk("model_last35", q[35].l, 1);
        end
        k = 0;
        fv = -1;
        fired = 0;
        while (k < 400) begin
            if (out_valid && fv < 0) fv = k;
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    out_ready = !(fv < 0 || k < fv + 10);
                    if (fv >= 0 && k == fv + 10) begin
                        chk("stall_reads", reads, 2);
                        chk("stall_valid", out_valid, 1);
                        chk("stall_data", out_data, 8'h00);
                    end
                end
                default: out_ready = 1;
            endcase
            if (mode == 3) begin
                start = pops == 10 && !fired;
                if (start) fired = 1;
            end
            if (mode == 4 && pops == 20) begin
                reset = 1;
                cycle();
                reset = 0;
                chk("rst_valid", out_valid, 0);
                chk("rst_rd_en", rd_en, 0);
                chk("rst_busy", busy, 0);
                return;
            end
            cycle();
            k++;
            if (done) break;
        end
        start = 0;
        chk("frame_done", done, 1);
        chk("frame_words", pops, M * N);
        chk("frame_reads", reads, M * N);
        if (mode == 0) begin
            chk("first_valid_cycle", fv, 2);
            chk("done_cycle", k, 38);
            chk("last_word_data", last_hs_data, 8'h2D);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        for (int a = 0; a < 32; a++) ram_p[a] = 8'(a) ^ 8'hA5;
        repeat (3) cycle();
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_rd_en0", rd_en, 0);
        chk("rst_rd_addr0", rd_addr, 0);
        chk("rst_out_valid0", out_valid, 0);
        chk("rst_out_data0", out_data, 0);
        chk("rst_out_row0", out_row, 0);
        chk("rst_out_col0", out_col, 0);
        chk("rst_out_last0", out_last, 0);
        reset = 0;
        mon = 1;
        fill_ram(1);
        run_frame(0);
        run_frame(2);
        for (int f = 0; f < 3; f++) begin
            fill_ram(0);
            run_frame(1);
        end
        fill_ram(0);
        run_frame(3);
        fill_ram(0);
        run_frame(4);
        fill_ram(0);
        run_frame(0 + 1);
        p_start = 1;
        cycle();
        p_start = 0;
        g = 0;
        while (!p_done && g < 200) begin
            cycle();
            g++;
        end
        chk("p_done", p_done, 1);
        chk("p_reads", p_addr_q.size(), 15);
        chk("p_words", p_word_q.size(), 15);
        for (int n = 0; n < 15 && n < p_addr_q.size() && n < p_word_q.size(); n++) begin
            chk("p_addr", p_addr_q[n], ((n / 3) << 2) | (n % 3));
            chk("p_data", p_word_q[n].d, 8'(((n / 3) << 2) | (n % 3)) ^ 8'hA5);
            chk("p_row", p_word_q[n].r, n / 3);
            chk("p_col", p_word_q[n].c, n % 3);
            chk("p_last", p_word_q[n].l, n == 14);
        end
        repeat (3) cycle();
        chk("done_count", done_cnt, 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eda_result_reader.md
# eda_result_reader

Read-out engine for the regional-maximum datapath. After the image has been written and the regional-max iteration has finished, this block scans the result RAM in row-major order. It issues read strobes using the same `{i, j}` address format the write side uses, and streams each result word out on a valid/ready interface. Row/column tags and an end-of-frame flag go with each word. It sits between the result RAM read port and the downstream consumer (host DMA or output FIFO).

## Interface
- `M`, 6: image rows.
- `N`, 6: image columns.
- `DATA_WIDTH`, 8: width of one result word from the RAM.
- `I_WIDTH`, `$clog2(M)`: row index width.
- `J_WIDTH`, `$clog2(N)`: column index width.
- `ADDR_WIDTH`, `I_WIDTH+J_WIDTH`: RAM address width. Address is `{i, j}`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle pulse that begins a frame scan. Ignored while `busy`=1.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse after the last word handshakes.
- `rd_en`  out  1  RAM read strobe.
- `rd_addr`  out  ADDR_WIDTH  RAM read address `{i, j}`.
- `rd_data`  in  DATA_WIDTH  RAM data, valid exactly 1 cycle after `rd_en`.
- `out_valid`  out  1  stream word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_WIDTH  result word.
- `out_row`  out  I_WIDTH  row of `out_data`.
- `out_col`  out  J_WIDTH  column of `out_data`.
- `out_last`  out  1  high on the word at (M-1, N-1).

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → DRAIN when the read for (M-1, N-1) issues.
  - DRAIN → DONE when the last word handshakes.
  - DONE → IDLE unconditionally after 1 cycle. `done`=1 only in DONE.
- Read counters `ri`/`rj`:
  - Reset to 0 on accepted `start`.
  - `rj` wraps at N-1 → 0 and increments `ri`.
  - `ri` stops at M-1. The addresses for `j` ≥ N and `i` ≥ M, which exist because of power-of-2 width padding, are never issued.
- Output buffer:
  - 2-entry FIFO holding {data, row, col, last}. Row/col/last tags are carried in a 1-deep pipeline register alongside the outstanding read.
  - Credit rule: issue `rd_en` in RUN only when (occupancy + outstanding − pop_this_cycle) < 2. With `out_ready` held high this sustains 1 word/cycle.
  - `rd_data` is captured unconditionally on the cycle after `rd_en`. The credit rule guarantees there is space.
- Stream:
  - `out_valid` = FIFO non-empty.
  - Handshake is `out_valid && out_ready`.
  - `out_data`, `out_row`, `out_col` and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.
- `start` while busy: no effect; counters and FIFO are untouched.
- `reset` mid-scan:
  - FSM goes to IDLE, counters and FIFO are cleared, and any outstanding read data is discarded.
  - The next cycle has `out_valid`=0 and `rd_en`=0.
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0.

## Timing
- `start` is sampled at edge E0. `rd_en`=1 with `rd_addr`={0,0} in the following cycle, sampled at E1.
- `rd_data` is captured at E2, and `out_valid`=1 from E2. Start-to-first-valid latency is 2 cycles.
- With `out_ready`=1 throughout:
  - M·N words handshake on M·N consecutive cycles.
  - The last handshake is at E2+M·N−1.
  - `done` is high in the following cycle, and `busy` drops with it.
- `rd_en` is a 1-cycle strobe per address. No address is read twice in one frame.
- Stall: if `out_ready`=0, at most 2 further reads issue (FIFO fills), then `rd_en` stays 0 until a pop.

## Test plan
- **Basic scan, M=N=6, RAM[a]=a, `out_ready`=1:**
  - `start` → 36 words with `out_data`=0x00,0x01,…,0x05,0x08,…,0x2D on consecutive cycles.
  - (row, col) goes (0,0)…(5,5).
  - `out_last` is high only on 0x2D.
  - `done` pulses 1 cycle after that word, 38 cycles after E0.
- **Backpressure, `out_ready`=0 for 10 cycles after first valid:**
  - `rd_en` issues exactly 2 reads, then stays low.
  - `out_data`=0x00 is held stable.
  - After release, all 36 words arrive in order with none dropped or duplicated.
- **Random `out_ready` (50%), 3 frames back-to-back:**
  - Exact sequence on each frame.
  - FIFO never overflows.
  - `busy` never drops mid-frame.
- **`start` pulsed at word 10 of a scan:** ignored. The sequence stays intact and `done` fires once.
- **`reset` asserted at word 20 with an outstanding read:**
  - The next cycle has `out_valid`=0, `rd_en`=0, `busy`=0.
  - A new `start` scans again from (0,0) with no stale data.
- **Address padding, M=5, N=3:**
  - `rd_addr` sequence is {0,0},{0,1},{0,2},{1,0},… .
  - Never `j`=3.
  - 15 words, with `out_last` on (4,2).
